// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int                WORD_W          = 32;
  localparam logic [WORD_W-1:0] ADDR_ALIGN_MASK = 32'h3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
    return |(addr & ADDR_ALIGN_MASK);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset value, redirect load, post-delivery increment.
// A redirect load wins over an increment in the same cycle.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned       PC_INC   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_pc_i,
  input  logic              inc_i,
  output logic [WORD_W-1:0] pc_o
);

  localparam logic [WORD_W-1:0] PC_STEP = WORD_W'(PC_INC);

  logic [WORD_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i)     pc_d = load_pc_i;
    else if (inc_i) pc_d = pc_q + PC_STEP;  // wraps naturally at 2^32
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC ownership, req/gnt/rvalid read port, IR delivery strobe.
// Optional macro FETCH_ALIGN_CHECK_EN turns misaligned fetches into a fetch_err pulse.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned       PC_INC   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_go,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic [WORD_W-1:0] pc,
  output logic              busy,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] R_data,
  output logic              IRWr,
  output logic              fetch_err
);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] r_data_q, r_data_d;
  logic              irwr_q, irwr_d;
  logic              kill_q, kill_d;
  logic [WORD_W-1:0] pc_q;
  logic              pc_inc;
  logic              complete;
  logic              launch;
  logic [WORD_W-1:0] launch_addr;
`ifdef FETCH_ALIGN_CHECK_EN
  logic              fetch_err_q, fetch_err_d;
`endif

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (redirect_valid),
    .load_pc_i (redirect_pc),
    .inc_i     (pc_inc),
    .pc_o      (pc_q)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    r_data_d    = r_data_q;
    irwr_d      = 1'b0;
    kill_d      = kill_q;
    pc_inc      = 1'b0;
    complete    = 1'b0;
    launch      = 1'b0;
    launch_addr = pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fetch_err_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (fetch_go) begin
          launch      = 1'b1;
          launch_addr = redirect_valid ? redirect_pc : pc_q;
        end
      end
      REQ: begin
        if (redirect_valid) kill_d = 1'b1;
        if (mem_gnt) begin
          if (mem_rvalid) complete = 1'b1;
          else            state_d  = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) kill_d = 1'b1;
        if (mem_rvalid)     complete = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A redirect on the response cycle counts as a kill; the pc already holds the new target.
    if (complete) begin
      if (kill_q || redirect_valid) begin
        kill_d      = 1'b0;
        launch      = 1'b1;
        launch_addr = redirect_valid ? redirect_pc : pc_q;
      end else begin
        r_data_d = mem_rdata;
        irwr_d   = 1'b1;
        pc_inc   = 1'b1;
        state_d  = IDLE;
      end
    end

    if (launch) begin
      state_d    = REQ;
      mem_addr_d = launch_addr & ~ADDR_ALIGN_MASK;
`ifdef FETCH_ALIGN_CHECK_EN
      if (is_misaligned(launch_addr)) begin
        state_d     = IDLE;
        mem_addr_d  = mem_addr_q;
        fetch_err_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      r_data_q   <= '0;
      irwr_q     <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      r_data_q   <= r_data_d;
      irwr_q     <= irwr_d;
      kill_q     <= kill_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_err_q <= 1'b0;
    else        fetch_err_q <= fetch_err_d;
  end
  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign pc       = pc_q;
  assign busy     = (state_q != IDLE);
  assign mem_req  = (state_q == REQ);
  assign mem_addr = mem_addr_q;
  assign R_data   = r_data_q;
  assign IRWr     = irwr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a cycle table for the main flows plus
// hand sequences for misaligned fetch and reset during an outstanding read.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_go, redirect_valid, mem_gnt, mem_rvalid;
  logic [31:0] redirect_pc, mem_rdata;
  logic [31:0] pc, mem_addr, R_data;
  logic        busy, mem_req, IRWr, fetch_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_go       (fetch_go),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .busy           (busy),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .R_data         (R_data),
    .IRWr           (IRWr),
    .fetch_err      (fetch_err)
  );

  typedef struct {
    logic        go, rv;
    logic [31:0] rpc;
    logic        gnt, rval;
    logic [31:0] rdata;
    logic [31:0] e_pc;
    logic        e_busy, e_req;
    logic [31:0] e_addr;
    logic        e_irwr;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are registered, so they are sampled 1ns later.
  task automatic drive(input logic go, input logic rv, input logic [31:0] rpc,
                       input logic gnt, input logic rval, input logic [31:0] rdata);
    @(negedge clk);
    fetch_go       = go;
    redirect_valid = rv;
    redirect_pc    = rpc;
    mem_gnt        = gnt;
    mem_rvalid     = rval;
    mem_rdata      = rdata;
    #1;
  endtask

  function automatic vec_t mk(input logic go, input logic rv, input logic [31:0] rpc,
                              input logic gnt, input logic rval, input logic [31:0] rdata,
                              input logic [31:0] e_pc, input logic e_busy, input logic e_req,
                              input logic [31:0] e_addr, input logic e_irwr, input logic [31:0] e_rdata);
    vec_t v;
    v.go = go; v.rv = rv; v.rpc = rpc; v.gnt = gnt; v.rval = rval; v.rdata = rdata;
    v.e_pc = e_pc; v.e_busy = e_busy; v.e_req = e_req; v.e_addr = e_addr;
    v.e_irwr = e_irwr; v.e_rdata = e_rdata;
    return v;
  endfunction

  initial begin
    //               go rv rpc           gnt rv  rdata          pc            bsy req addr          irw R_data
    // basic fetch: go at T, gnt T+1, rvalid T+2, IRWr at T+3
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,         32'h0,        0, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         32'h0,        1, 1, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h2002_0005, 32'h0,        1, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         32'h4,        0, 0, 32'h0,        1, 32'h2002_0005));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         32'h4,        0, 0, 32'h0,        0, 32'h2002_0005));
    // grant withheld three cycles
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,         32'h4,        0, 0, 32'h0,        0, 32'h2002_0005));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         32'h4,        1, 1, 32'h4,        0, 32'h2002_0005));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         32'h4,        1, 1, 32'h4,        0, 32'h2002_0005));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         32'h4,        1, 1, 32'h4,        0, 32'h2002_0005));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         32'h4,        1, 1, 32'h4,        0, 32'h2002_0005));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h1111_2222, 32'h4,        1, 0, 32'h4,        0, 32'h2002_0005));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         32'h8,        0, 0, 32'h4,        1, 32'h1111_2222));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         32'h8,        0, 0, 32'h4,        0, 32'h1111_2222));
    // redirect during WAIT: response dropped, automatic refetch at 0x40
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,         32'h8,        0, 0, 32'h4,        0, 32'h1111_2222));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         32'h8,        1, 1, 32'h8,        0, 32'h1111_2222));
    vecs.push_back(mk(0, 1, 32'h40,       0, 0, 32'h0,         32'h8,        1, 0, 32'h8,        0, 32'h1111_2222));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hBADB_AD00, 32'h40,       1, 0, 32'h8,        0, 32'h1111_2222));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         32'h40,       1, 1, 32'h40,       0, 32'h1111_2222));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h3333_4444, 32'h40,       1, 0, 32'h40,       0, 32'h1111_2222));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         32'h44,       0, 0, 32'h40,       1, 32'h3333_4444));
    // gnt and rvalid together in REQ
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,         32'h44,       0, 0, 32'h40,       0, 32'h3333_4444));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h5555_6666, 32'h44,       1, 1, 32'h44,       0, 32'h3333_4444));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         32'h48,       0, 0, 32'h44,       1, 32'h5555_6666));
    // redirect in IDLE, then PC wrap from 0xFFFF_FFFC
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFC,0, 0, 32'h0,         32'h48,       0, 0, 32'h44,       0, 32'h5555_6666));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,         32'hFFFF_FFFC,0, 0, 32'h44,       0, 32'h5555_6666));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h7777_8888, 32'hFFFF_FFFC,1, 1, 32'hFFFF_FFFC,0, 32'h5555_6666));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         32'h0,        0, 0, 32'hFFFF_FFFC,1, 32'h7777_8888));
    // fetch_go while busy is ignored; redirect on the rvalid cycle kills and refetches
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,         32'h0,        0, 0, 32'hFFFF_FFFC,0, 32'h7777_8888));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,         32'h0,        1, 1, 32'h0,        0, 32'h7777_8888));
    vecs.push_back(mk(1, 1, 32'h80,       0, 1, 32'h9999_0000, 32'h0,        1, 0, 32'h0,        0, 32'h7777_8888));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'hAAAA_0000, 32'h80,       1, 1, 32'h80,       0, 32'h7777_8888));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         32'h84,       0, 0, 32'h80,       1, 32'hAAAA_0000));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         32'h84,       0, 0, 32'h80,       0, 32'hAAAA_0000));

    rst_n = 1'b0;
    fetch_go = 0; redirect_valid = 0; redirect_pc = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_pc",     pc,               32'h0);
    check("rst_req",    {31'b0, mem_req}, 32'h0);
    check("rst_irwr",   {31'b0, IRWr},    32'h0);
    check("rst_rdata",  R_data,           32'h0);
    check("rst_busy",   {31'b0, busy},    32'h0);
    check("rst_ferr",   {31'b0, fetch_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].go, vecs[i].rv, vecs[i].rpc, vecs[i].gnt, vecs[i].rval, vecs[i].rdata);
      check($sformatf("v%0d_pc", i),    pc,                 vecs[i].e_pc);
      check($sformatf("v%0d_busy", i),  {31'b0, busy},      {31'b0, vecs[i].e_busy});
      check($sformatf("v%0d_req", i),   {31'b0, mem_req},   {31'b0, vecs[i].e_req});
      check($sformatf("v%0d_addr", i),  mem_addr,           vecs[i].e_addr);
      check($sformatf("v%0d_irwr", i),  {31'b0, IRWr},      {31'b0, vecs[i].e_irwr});
      check($sformatf("v%0d_rdata", i), R_data,             vecs[i].e_rdata);
      check($sformatf("v%0d_ferr", i),  {31'b0, fetch_err}, 32'h0);
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned PC: error pulse instead of a request
    drive(0, 1, 32'h42, 0, 0, 32'h0);
    drive(1, 0, 32'h0,  0, 0, 32'h0);
    check("mis_pc0",  pc, 32'h42);
    drive(0, 0, 32'h0,  0, 0, 32'h0);
    check("mis_ferr", {31'b0, fetch_err}, 32'h1);
    check("mis_req",  {31'b0, mem_req},   32'h0);
    check("mis_busy", {31'b0, busy},      32'h0);
    check("mis_irwr", {31'b0, IRWr},      32'h0);
    check("mis_pc1",  pc, 32'h42);
    drive(0, 0, 32'h0,  0, 0, 32'h0);
    check("mis_ferr_clr", {31'b0, fetch_err}, 32'h0);
    check("mis_irwr2",    {31'b0, IRWr},      32'h0);
`else
    // Misaligned PC without the check: the aligned word is fetched
    drive(1, 1, 32'h102, 0, 0, 32'h0);
    drive(0, 0, 32'h0,   1, 1, 32'hBBBB_0000);
    check("mis_req",   {31'b0, mem_req}, 32'h1);
    check("mis_addr",  mem_addr,         32'h100);
    check("mis_pc0",   pc,               32'h102);
    drive(0, 0, 32'h0,   0, 0, 32'h0);
    check("mis_irwr",  {31'b0, IRWr},    32'h1);
    check("mis_rdata", R_data,           32'hBBBB_0000);
    check("mis_pc1",   pc,               32'h106);
    check("mis_ferr",  {31'b0, fetch_err}, 32'h0);
`endif

    // Reset while a read is outstanding; the late response must be dropped
    drive(0, 1, 32'h200, 0, 0, 32'h0);
    drive(1, 0, 32'h0,   0, 0, 32'h0);
    drive(0, 0, 32'h0,   1, 0, 32'h0);
    check("rw_addr", mem_addr,         32'h200);
    check("rw_req",  {31'b0, mem_req}, 32'h1);
    drive(0, 0, 32'h0,   0, 0, 32'h0);
    check("rw_busy", {31'b0, busy},    32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rw_rst_pc",   pc,               32'h0);
    check("rw_rst_busy", {31'b0, busy},    32'h0);
    check("rw_rst_addr", mem_addr,         32'h0);
    check("rw_rst_rd",   R_data,           32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 32'h0,   0, 1, 32'hCCCC_0000);
    drive(0, 0, 32'h0,   0, 0, 32'h0);
    check("rw_irwr",  {31'b0, IRWr},    32'h0);
    check("rw_busy2", {31'b0, busy},    32'h0);
    check("rw_pc",    pc,               32'h0);
    check("rw_rdata", R_data,           32'h0);
    check("rw_req2",  {31'b0, mem_req}, 32'h0);
    drive(0, 0, 32'h0,   0, 0, 32'h0);
    check("rw_irwr2", {31'b0, IRWr},    32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, expected finish before 200000ns");
    $fatal(1);
  end

endmodule
